regbus_capture_reader: RTL
==========================

Name: regbus_capture_reader

Overview:
- Register-bus initiator that drives the capture core's reg interface from the master side.
- Arms a capture, reads the buffer size, polls status until the capture is available, then drains the buffer and emits it as a 32-bit valid/ready stream.
- Sits between the capture core and a host link (UART/DMA framer).

Parameters:
N, 1, sample width of the attached capture core; words per sample WPS = (N+31)/32
TIMEOUT, 1024, cycles allowed from regreq to regack before error
POLL_GAP, 16, idle cycles between status polls

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin arm/capture/drain sequence (ignored when busy)
abort  in  1  pulse: cancel sequence
trans  in  1  transition-only capture mode, forwarded to core
tpos  in  16  trigger position, forwarded to core
busy  out  1  sequence in progress
done  out  1  one-cycle pulse: drain complete
errcode  out  2  0 none, 1 regerr, 2 timeout, 3 aborted; valid with done, held until next start
regreq  out  1  request pulse
regwr  out  1  write qualifier
regaddr  out  12  register address
regwdata  out  32  write data
regack  in  1  responder ack
regerr  in  1  responder error, valid with regack
regrdata  in  32  read data, valid with regack
out_valid  out  1  stream word valid
out_ready  in  1  stream consumer ready
out_data  out  32  stream word
out_last  out  1  final word of drain

Behaviour:
- Core register map: 0 ctrl/status (write: bit0 start, bit1 abort, bit8 trans, [31:16] tpos; read: bit2 avail, bit3 running); 4 SIZ (read); 8 data step (read, one 32-bit word per read, LSW first within a sample).
- Bus rules:
  - regreq high exactly one cycle per transaction; at most one outstanding.
  - regwr/regaddr/regwdata held stable from the regreq cycle until regack.
  - regrdata is sampled on the regack cycle.
- Reset values: regreq 0, regwr 0, regaddr 0, regwdata 0, busy 0, done 0, errcode 0, out_valid 0, out_last 0, out_data 0.
- FSM:
  - IDLE: on start, latch trans/tpos, clear errcode, then go to ARM.
  - ARM: write addr 0 = {tpos,7'b0,trans,6'b0,0,1}.
  - SIZE: read addr 4 and latch siz. Total = siz*WPS, held in a 32-bit counter.
  - POLL: read addr 0. If avail, go to DRAIN. Otherwise wait POLL_GAP cycles and re-read.
  - DRAIN: issue a read of addr 8 only when out_valid is 0. On ack, load out_data, set out_valid, decrement the counter, and set out_last when the counter reaches 0. Hold out_valid/out_data until out_ready. After the last handshake, go to FIN.
  - FIN: pulse done, drop busy, return to IDLE.
- Total = 0: skip DRAIN, go to FIN, emit no stream words.
- Error handling:
  - regerr on any ack: errcode 1, go to FIN; no abort write.
  - Timeout counter reaching TIMEOUT without ack: errcode 2, go to FIN.
  - Any pending out_valid word stays valid until consumed, then FIN.
- Abort:
  - Latched sticky while busy.
  - Acted on at the next transaction boundary, after any outstanding ack or timeout.
  - Issue a write to addr 0 with bit1 set. Then errcode 3, go to FIN.
  - A pending stream word is discarded (out_valid cleared).
  - Abort in IDLE is ignored.
- start while busy: ignored.
- start and abort in the same IDLE cycle: start wins; the abort is latched and taken at the ARM ack.
- rst mid-transaction: immediate return to IDLE with reset values. A late regack after reset is ignored, because ack is only honoured in wait states.
- Latency: done follows the final out_ready handshake by 1 cycle.

Decomposition:
- Shared package holds:
  - register address constants (CTRL=0, SIZ=4, DATA=8);
  - status bit indices (AVAIL=2, RUNNING=3);
  - ctrl bit indices (START=0, ABORT=1, TRANS=8, TPOS_LSB=16);
  - errcode enum;
  - FSM state enum.
- One sub-module: regbus_master_port. It handles the single-transaction issue/hold/ack/timeout and presents a req/done/err/rdata handshake to the FSM.

Test Plan:
- N=8, stub SIZ=4, avail on 3rd poll, out_ready=1 -> writes 0 then reads 4, 0, 0, 0, then four reads of 8; stream words D0..D3 with out_last on D3; done with errcode 0.
- N=40 (WPS=2), SIZ=3 -> 6 data reads; out_last on the 6th word; poll gaps of exactly POLL_GAP cycles between status reads.
- out_ready low 10 cycles per word -> no data read issued while out_valid=1; out_data stable; no words lost or duplicated.
- Stub asserts regerr on the SIZ read -> errcode 1, done pulse, no addr 8 reads, no abort write.
- Stub never acks the ARM write, TIMEOUT=1024 -> after 1024 cycles errcode 2, done, regreq not re-pulsed.
- abort during POLL gap -> next transaction is a write to addr 0 with data bit1=1; errcode 3; done; busy=0. rst asserted mid-DRAIN -> IDLE, regreq=0, late ack ignored.

Source files
------------

// File: rtl/regbus_capture_reader_pkg.sv
// Shared definitions for the capture-core register-bus reader: register map,
// bit positions inside the ctrl/status word, error codes and sequencer states.
package regbus_capture_reader_pkg;

   localparam logic [11:0] ADDR_CTRL = 12'd0;
   localparam logic [11:0] ADDR_SIZ  = 12'd4;
   localparam logic [11:0] ADDR_DATA = 12'd8;

   localparam int STAT_AVAIL   = 2;
   localparam int STAT_RUNNING = 3;

   localparam int CTRL_START    = 0;
   localparam int CTRL_ABORT    = 1;
   localparam int CTRL_TRANS    = 8;
   localparam int CTRL_TPOS_LSB = 16;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_REGERR  = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_ABORTED = 2'd3
   } errcode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_SIZE,
      ST_POLL,
      ST_GAP,
      ST_DRAIN,
      ST_DRAIN_WAIT,
      ST_ABORT
   } state_t;

   function automatic logic [31:0] ctrl_word(input logic [15:0] tpos, input logic trans,
                                             input logic start, input logic abort);
      logic [31:0] w;
      w = '0;
      w[CTRL_TPOS_LSB +: 16] = tpos;
      w[CTRL_TRANS]          = trans;
      w[CTRL_ABORT]          = abort;
      w[CTRL_START]          = start;
      return w;
   endfunction

endpackage

// File: rtl/regbus_capture_reader_master_port.sv
// Single-outstanding register-bus initiator: issues one request, holds the
// command until ack, and reports completion, error or timeout to the sequencer.
module regbus_master_port
   import regbus_capture_reader_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [11:0] addr,
   input  logic [31:0] wdata,
   output logic        done,
   output logic        err,
   output logic        timeout,
   output logic [31:0] rdata,
   output logic        regreq,
   output logic        regwr,
   output logic [11:0] regaddr,
   output logic [31:0] regwdata,
   input  logic        regack,
   input  logic        regerr,
   input  logic [31:0] regrdata
);

   logic        pending;
   logic [31:0] wait_cnt;

   // Ack is only honoured while pending, so a stale ack after reset is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending  <= 1'b0;
         wait_cnt <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         timeout  <= 1'b0;
         rdata    <= '0;
         regreq   <= 1'b0;
         regwr    <= 1'b0;
         regaddr  <= '0;
         regwdata <= '0;
      end else begin
         regreq  <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         timeout <= 1'b0;
         if (pending) begin
            if (regack) begin
               pending <= 1'b0;
               done    <= 1'b1;
               err     <= regerr;
               rdata   <= regrdata;
            end else if (wait_cnt == 32'(TIMEOUT - 1)) begin
               pending <= 1'b0;
               done    <= 1'b1;
               timeout <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + 32'd1;
            end
         end else if (req) begin
            regreq   <= 1'b1;
            regwr    <= wr;
            regaddr  <= addr;
            regwdata <= wdata;
            pending  <= 1'b1;
            wait_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/regbus_capture_reader.sv
// Sequencer that arms the capture core, reads its size, polls for availability
// and drains the buffer as a 32-bit valid/ready stream.
module regbus_capture_reader
   import regbus_capture_reader_pkg::*;
#(
   parameter int N        = 1,
   parameter int TIMEOUT  = 1024,
   parameter int POLL_GAP = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        trans,
   input  logic [15:0] tpos,
   output logic        busy,
   output logic        done,
   output logic [1:0]  errcode,
   output logic        regreq,
   output logic        regwr,
   output logic [11:0] regaddr,
   output logic [31:0] regwdata,
   input  logic        regack,
   input  logic        regerr,
   input  logic [31:0] regrdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last
);

   localparam int WPS = (N + 31) / 32;

   state_t      state;
   logic        mp_req;
   logic        mp_wr;
   logic [11:0] mp_addr;
   logic [31:0] mp_wdata;
   logic        mp_done;
   logic        mp_err;
   logic        mp_timeout;
   logic [31:0] mp_rdata;
   logic        trans_q;
   logic [15:0] tpos_q;
   logic        abort_pend;
   logic        abort_now;
   logic [31:0] remaining;
   logic [15:0] gap_cnt;

   assign abort_now = abort_pend | abort;

   regbus_master_port #(.TIMEOUT(TIMEOUT)) u_port (
      .clk      (clk),
      .rst      (rst),
      .req      (mp_req),
      .wr       (mp_wr),
      .addr     (mp_addr),
      .wdata    (mp_wdata),
      .done     (mp_done),
      .err      (mp_err),
      .timeout  (mp_timeout),
      .rdata    (mp_rdata),
      .regreq   (regreq),
      .regwr    (regwr),
      .regaddr  (regaddr),
      .regwdata (regwdata),
      .regack   (regack),
      .regerr   (regerr),
      .regrdata (regrdata)
   );

   // Each transaction completion is a decision point: errors end the run,
   // a pending abort replaces the next access with the abort write.
   // The gap counter starts at POLL_GAP-3 to absorb the fixed issue latency,
   // so the status-read spacing is exactly POLL_GAP idle cycles (POLL_GAP >= 3).
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         errcode    <= ERR_NONE;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         mp_req     <= 1'b0;
         mp_wr      <= 1'b0;
         mp_addr    <= '0;
         mp_wdata   <= '0;
         trans_q    <= 1'b0;
         tpos_q     <= '0;
         abort_pend <= 1'b0;
         remaining  <= '0;
         gap_cnt    <= '0;
      end else begin
         mp_req <= 1'b0;
         done   <= 1'b0;
         if (busy && abort) abort_pend <= 1'b1;
         case (state)
            ST_IDLE: if (start) begin
               busy       <= 1'b1;
               errcode    <= ERR_NONE;
               trans_q    <= trans;
               tpos_q     <= tpos;
               abort_pend <= abort;
               mp_req     <= 1'b1;
               mp_wr      <= 1'b1;
               mp_addr    <= ADDR_CTRL;
               mp_wdata   <= ctrl_word(tpos, trans, 1'b1, 1'b0);
               state      <= ST_ARM;
            end
            ST_ARM, ST_SIZE, ST_POLL, ST_DRAIN_WAIT: if (mp_done) begin
               if (mp_err || mp_timeout) begin
                  errcode    <= mp_err ? ERR_REGERR : ERR_TIMEOUT;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  abort_pend <= 1'b0;
                  state      <= ST_IDLE;
               end else if (abort_now) begin
                  mp_req   <= 1'b1;
                  mp_wr    <= 1'b1;
                  mp_addr  <= ADDR_CTRL;
                  mp_wdata <= ctrl_word(tpos_q, trans_q, 1'b0, 1'b1);
                  state    <= ST_ABORT;
               end else if (state == ST_ARM) begin
                  mp_req  <= 1'b1;
                  mp_wr   <= 1'b0;
                  mp_addr <= ADDR_SIZ;
                  state   <= ST_SIZE;
               end else if (state == ST_SIZE) begin
                  remaining <= mp_rdata * 32'(WPS);
                  mp_req    <= 1'b1;
                  mp_wr     <= 1'b0;
                  mp_addr   <= ADDR_CTRL;
                  state     <= ST_POLL;
               end else if (state == ST_POLL) begin
                  if (!mp_rdata[STAT_AVAIL]) begin
                     gap_cnt <= 16'(POLL_GAP - 3);
                     state   <= ST_GAP;
                  end else if (remaining == 32'd0) begin
                     done       <= 1'b1;
                     busy       <= 1'b0;
                     abort_pend <= 1'b0;
                     state      <= ST_IDLE;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end else begin
                  out_data  <= mp_rdata;
                  out_valid <= 1'b1;
                  out_last  <= (remaining == 32'd1);
                  remaining <= remaining - 32'd1;
                  state     <= ST_DRAIN;
               end
            end
            ST_GAP: begin
               if (abort_now) begin
                  mp_req   <= 1'b1;
                  mp_wr    <= 1'b1;
                  mp_addr  <= ADDR_CTRL;
                  mp_wdata <= ctrl_word(tpos_q, trans_q, 1'b0, 1'b1);
                  state    <= ST_ABORT;
               end else if (gap_cnt == 16'd0) begin
                  mp_req  <= 1'b1;
                  mp_wr   <= 1'b0;
                  mp_addr <= ADDR_CTRL;
                  state   <= ST_POLL;
               end else begin
                  gap_cnt <= gap_cnt - 16'd1;
               end
            end
            ST_DRAIN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     out_last   <= 1'b0;
                     done       <= 1'b1;
                     busy       <= 1'b0;
                     abort_pend <= 1'b0;
                     state      <= ST_IDLE;
                  end
               end else if (abort_now) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  mp_req    <= 1'b1;
                  mp_wr     <= 1'b1;
                  mp_addr   <= ADDR_CTRL;
                  mp_wdata  <= ctrl_word(tpos_q, trans_q, 1'b0, 1'b1);
                  state     <= ST_ABORT;
               end else if (!out_valid) begin
                  mp_req  <= 1'b1;
                  mp_wr   <= 1'b0;
                  mp_addr <= ADDR_DATA;
                  state   <= ST_DRAIN_WAIT;
               end
            end
            ST_ABORT: if (mp_done) begin
               errcode    <= ERR_ABORTED;
               done       <= 1'b1;
               busy       <= 1'b0;
               abort_pend <= 1'b0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
